// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 data mux.
// Holds a registered grant until ack, requester withdrawal or timeout.
module rr_sel_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       valid,
    output logic       timeout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       release_grant;

    // Rotating-priority scan starting just after the last released channel
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = 2'(last_q + 2'(i));
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Grant FSM: IDLE scan, GRANT hold until release, one-cycle GAP
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        sel_d         = sel_q;
        grant_d       = grant_q;
        valid_d       = valid_q;
        timeout_d     = 1'b0;
        release_grant = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                grant_d = 4'b0000;
                if (pick_found) begin
                    sel_d   = pick_idx;
                    grant_d = 4'b0001 << pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    release_grant = 1'b1;
                end else if (!req[sel_q]) begin
                    release_grant = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    release_grant = 1'b1;
                    timeout_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (release_grant) begin
                    valid_d = 1'b0;
                    grant_d = 4'b0000;
                    last_d  = sel_q;
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end
            end
            GAP: begin
                valid_d = 1'b0;
                grant_d = 4'b0000;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                grant_d = 4'b0000;
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset restores channel 0 as top priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            last_q    <= 2'd3;
            sel_q     <= 2'd0;
            grant_q   <= 4'b0000;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Scoreboard bench for rr_sel_arbiter: directed grants pushed as expectations,
// an independent negedge monitor pops and checks every grant it observes.
module tb_rr_sel_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       timeout;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] grant;
        int         len;
        logic       to;
        int         gap;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have_cur;
    bit   prev_valid;
    int   len_cnt;
    int   low_cnt;
    int   checks;
    int   errors;

    rr_sel_arbiter #(.TIMEOUT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .sel     (sel),
        .grant   (grant),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per rising valid, checks hold and release
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            have_cur   = 1'b0;
        end else begin
            if (valid && !prev_valid) begin
                len_cnt = 0;
                if (q.size() == 0) begin
                    have_cur = 1'b0;
                    chk("unexpected_grant", 1, 0);
                end else begin
                    cur      = q.pop_front();
                    have_cur = 1'b1;
                    chk("grant_sel", 32'(sel), 32'(cur.sel));
                    chk("grant_onehot", 32'(grant), 32'(cur.grant));
                    if (cur.gap >= 0)
                        chk("idle_gap", low_cnt, cur.gap);
                end
            end
            if (valid) begin
                len_cnt++;
                chk("timeout_in_grant", 32'(timeout), 0);
                if (have_cur) begin
                    chk("sel_stable", 32'(sel), 32'(cur.sel));
                    chk("grant_stable", 32'(grant), 32'(cur.grant));
                end
            end else begin
                chk("grant_idle", 32'(grant), 0);
                if (prev_valid) begin
                    if (have_cur) begin
                        if (cur.len >= 0)
                            chk("valid_len", len_cnt, cur.len);
                        chk("timeout_pulse", 32'(timeout), 32'(cur.to));
                    end
                    have_cur = 1'b0;
                    low_cnt  = 1;
                end else begin
                    chk("timeout_quiet", 32'(timeout), 0);
                    low_cnt++;
                end
            end
            prev_valid = valid;
        end
    end

    // Push one expected grant, then serve it: ack or drop on GRANT cycle k
    task automatic serve(input logic [1:0] s, input int ack_at,
                         input int drop_at, input int len,
                         input logic to, input int gap);
        exp_t e;
        int   w;
        int   k;
        e.sel   = s;
        e.grant = 4'b0001 << s;
        e.len   = len;
        e.to    = to;
        e.gap   = gap;
        q.push_back(e);
        w = 0;
        while (!valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!valid) begin
            chk("wait_valid", 0, 1);
            return;
        end
        k = 0;
        while (valid && k < 300) begin
            k++;
            ack = (k == ack_at);
            if (k == drop_at)
                req[s] = 1'b0;
            @(posedge clk); #1;
        end
        ack = 1'b0;
    endtask

    initial begin
        int w;
        exp_t e;
        checks   = 0;
        errors   = 0;
        low_cnt  = 0;
        len_cnt  = 0;
        have_cur = 1'b0;
        prev_valid = 1'b0;
        rst = 1'b1;
        req = 4'b0000;
        ack = 1'b0;
        #3;
        chk("rst_sel", 32'(sel), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Full contention with immediate ack: 0,1,2,3,0
        req = 4'b1111;
        serve(2'd0, 1, 0, 1, 1'b0, -1);
        serve(2'd1, 1, 0, 1, 1'b0, 2);
        serve(2'd2, 1, 0, 1, 1'b0, 2);
        serve(2'd3, 1, 0, 1, 1'b0, 2);
        serve(2'd0, 1, 0, 1, 1'b0, 2);

        // Lone requester: ack on 4th cycle, then re-granted
        req = 4'b0100;
        serve(2'd2, 4, 0, 4, 1'b0, 2);
        serve(2'd2, 1, 0, 1, 1'b0, 2);

        // No ack: timeout after 8 cycles, then rotation moves to ch1
        req = 4'b0001;
        serve(2'd0, 0, 0, 8, 1'b1, 2);
        req = 4'b0011;
        serve(2'd1, 2, 0, 2, 1'b0, 2);

        // Requester withdraws on 2nd GRANT cycle
        req = 4'b0010;
        serve(2'd1, 0, 2, 2, 1'b0, 2);
        req = 4'b1111;
        serve(2'd2, 1, 0, 1, 1'b0, 2);

        // ack on the final counted cycle: normal release, no timeout
        req = 4'b1000;
        serve(2'd3, 8, 0, 8, 1'b0, 2);

        // Asynchronous reset in the middle of a sel=3 grant
        e.sel   = 2'd3;
        e.grant = 4'b1000;
        e.len   = -1;
        e.to    = 1'b0;
        e.gap   = 2;
        q.push_back(e);
        w = 0;
        while (!valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("pre_reset_valid", 32'(valid), 1);
        chk("pre_reset_sel", 32'(sel), 3);
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_sel", 32'(sel), 0);
        chk("async_grant", 32'(grant), 0);
        chk("async_valid", 32'(valid), 0);
        chk("async_timeout", 32'(timeout), 0);
        req = 4'b1010;
        @(posedge clk); #1;
        rst = 1'b0;
        serve(2'd1, 1, 0, 1, 1'b0, -1);

        req = 4'b0000;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
